// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch (I), load/store (D) and memory-side signals around the arbiter.
// master: the arbiter's view; slave: the requesters plus memory that surround it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Handshake: a requester raises req with stable addr/data and holds it until its
  // one-cycle done pulse; rdata/err are meaningful only while done=1. The memory sees
  // exactly one strobe cycle per access and answers with m_ready (m_rdata valid with it).
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_done;
  logic              i_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic [31:0]       d_rdata;
  logic              d_done;
  logic              d_err;

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_rstrb;
  logic [31:0]       m_rdata;
  logic              m_ready;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wstrb, m_rdata, m_ready,
    output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
           m_addr, m_wdata, m_wstrb, m_rstrb
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wstrb, m_rdata, m_ready,
    input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
           m_addr, m_wdata, m_wstrb, m_rstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a watchdog that aborts a stalled access and reports an error to the winner.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  mem_port_arbiter_if.master bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic              last_d, last_d_n;
  logic              owner_d, owner_d_n;
  logic [CNT_W-1:0]  watchdog, watchdog_n;
  logic [3:0]        wstrb_lat, wstrb_lat_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [31:0]       m_wdata_n;
  logic [3:0]        m_wstrb_n;
  logic              m_rstrb_n;
  logic              i_done_n, i_err_n, d_done_n, d_err_n;
  logic [31:0]       i_rdata_n, d_rdata_n;
  logic              pick_d;
  logic              resp_go, resp_err;
  logic [31:0]       resp_data;

  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    last_d_n    = last_d;
    owner_d_n   = owner_d;
    watchdog_n  = watchdog;
    wstrb_lat_n = wstrb_lat;
    m_addr_n    = bus.m_addr;
    m_wdata_n   = bus.m_wdata;
    m_wstrb_n   = 4'b0000;
    m_rstrb_n   = 1'b0;
    pick_d      = 1'b0;
    resp_go     = 1'b0;
    resp_err    = 1'b0;
    resp_data   = 32'h0;

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On a tie the side that did not win last time goes first.
          pick_d      = bus.d_req && (!bus.i_req || !last_d);
          owner_d_n   = pick_d;
          last_d_n    = pick_d;
          m_addr_n    = pick_d ? bus.d_addr : bus.i_addr;
          m_wdata_n   = pick_d ? bus.d_wdata : 32'h0;
          wstrb_lat_n = pick_d ? bus.d_wstrb : 4'b0000;
          m_wstrb_n   = pick_d ? bus.d_wstrb : 4'b0000;
          m_rstrb_n   = !pick_d || (bus.d_wstrb == 4'b0000);
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          resp_go   = 1'b1;
          resp_data = (wstrb_lat != 4'b0000) ? 32'h0 : bus.m_rdata;
          state_n   = RESP;
        end else begin
          watchdog_n = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_ready) begin
          resp_go   = 1'b1;
          resp_data = (wstrb_lat != 4'b0000) ? 32'h0 : bus.m_rdata;
          state_n   = RESP;
        end else if (watchdog == WD_LAST) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
          state_n  = RESP;
        end else begin
          watchdog_n = watchdog + 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Only the current owner ever sees done/rdata/err; the other side stays at zero.
    i_done_n  = resp_go && !owner_d;
    i_err_n   = resp_go && !owner_d && resp_err;
    i_rdata_n = (resp_go && !owner_d) ? resp_data : 32'h0;
    d_done_n  = resp_go && owner_d;
    d_err_n   = resp_go && owner_d && resp_err;
    d_rdata_n = (resp_go && owner_d) ? resp_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      owner_d     <= 1'b0;
      watchdog    <= '0;
      wstrb_lat   <= 4'b0000;
      bus.m_addr  <= '0;
      bus.m_wdata <= 32'h0;
      bus.m_wstrb <= 4'b0000;
      bus.m_rstrb <= 1'b0;
      bus.i_done  <= 1'b0;
      bus.i_err   <= 1'b0;
      bus.i_rdata <= 32'h0;
      bus.d_done  <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= 32'h0;
    end else begin
      state       <= state_n;
      last_d      <= last_d_n;
      owner_d     <= owner_d_n;
      watchdog    <= watchdog_n;
      wstrb_lat   <= wstrb_lat_n;
      bus.m_addr  <= m_addr_n;
      bus.m_wdata <= m_wdata_n;
      bus.m_wstrb <= m_wstrb_n;
      bus.m_rstrb <= m_rstrb_n;
      bus.i_done  <= i_done_n;
      bus.i_err   <= i_err_n;
      bus.i_rdata <= i_rdata_n;
      bus.d_done  <= d_done_n;
      bus.d_err   <= d_err_n;
      bus.d_rdata <= d_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester drivers, an address-keyed memory responder,
// and a monitor that checks strobes, grant order, latency and responses against queues.
module tb_mem_port_arbiter;
  localparam int TMO = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] dbg_state;
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;

  exp_t        exp_i_q[$];
  exp_t        exp_d_q[$];
  bit          grant_log[$];
  int          lat_tab[logic [31:0]];
  logic [31:0] dat_tab[logic [31:0]];
  int          strobe_cyc[2];
  bit          model_last_d = 1'b1;
  bit          req_i_s = 1'b0;
  bit          req_d_s = 1'b0;
  bit          prev_strobe = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_rdata"}, bus.i_rdata, 0);
    chk({tag, "_i_done"}, bus.i_done, 0);
    chk({tag, "_i_err"}, bus.i_err, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    chk({tag, "_d_done"}, bus.d_done, 0);
    chk({tag, "_d_err"}, bus.d_err, 0);
    chk({tag, "_m_addr"}, bus.m_addr, 0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 0);
    chk({tag, "_m_wstrb"}, bus.m_wstrb, 0);
    chk({tag, "_m_rstrb"}, bus.m_rstrb, 0);
    chk({tag, "_state_idle"}, dbg_state, 0);
  endtask

  // ---------------- memory responder ----------------
  int          mem_cnt = 0;
  int          mem_k = 0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_data = 32'h0;

  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.m_ready = 1'b0;
      bus.m_rdata = $urandom;
      if (!resetn) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_cnt++;
        if (mem_cnt == mem_k) begin
          bus.m_ready = 1'b1;
          bus.m_rdata = mem_data;
          mem_busy = 1'b0;
        end
      end else if (bus.m_rstrb || bus.m_wstrb != 4'b0000) begin
        mem_k    = lat_tab.exists(bus.m_addr) ? lat_tab[bus.m_addr] : 0;
        mem_data = dat_tab.exists(bus.m_addr) ? dat_tab[bus.m_addr] : 32'h0;
        if (mem_k == 0) begin
          bus.m_ready = 1'b1;
          bus.m_rdata = mem_data;
        end else begin
          mem_busy = 1'b1;
          mem_cnt = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      bit   strobe;
      bit   win_d;
      exp_t e;
      strobe = bus.m_rstrb || (bus.m_wstrb != 4'b0000);
      chk("strobe_exclusive", bus.m_rstrb && (bus.m_wstrb != 4'b0000), 0);
      if (strobe) begin
        chk("strobe_one_cycle", prev_strobe, 0);
        chk("strobe_has_req", req_i_s || req_d_s, 1);
        win_d = (req_i_s && req_d_s) ? !model_last_d : req_d_s;
        model_last_d = win_d;
        grant_log.push_back(win_d);
        strobe_cyc[win_d] = cyc;
        if ((win_d ? exp_d_q.size() : exp_i_q.size()) == 0) begin
          chk("strobe_expected", 0, 1);
        end else begin
          e = win_d ? exp_d_q[0] : exp_i_q[0];
          chk("grant_addr", bus.m_addr, e.addr);
          chk("grant_wstrb", bus.m_wstrb, e.wstrb);
          chk("grant_rstrb", bus.m_rstrb, (e.wstrb == 4'b0000));
          if (e.wstrb != 4'b0000) chk("grant_wdata", bus.m_wdata, e.wdata);
        end
      end
      chk("done_exclusive", bus.i_done && bus.d_done, 0);
      if (bus.i_done) begin
        if (exp_i_q.size() == 0) chk("i_done_expected", 0, 1);
        else begin
          e = exp_i_q.pop_front();
          chk("i_rdata", bus.i_rdata, e.rdata);
          chk("i_err", bus.i_err, e.err);
          chk("i_latency", cyc - strobe_cyc[0], e.lat);
        end
      end else begin
        chk("i_idle_zero", {bus.i_rdata, bus.i_err}, 0);
      end
      if (bus.d_done) begin
        if (exp_d_q.size() == 0) chk("d_done_expected", 0, 1);
        else begin
          e = exp_d_q.pop_front();
          chk("d_rdata", bus.d_rdata, e.rdata);
          chk("d_err", bus.d_err, e.err);
          chk("d_latency", cyc - strobe_cyc[1], e.lat);
        end
      end else begin
        chk("d_idle_zero", {bus.d_rdata, bus.d_err}, 0);
      end
      prev_strobe = strobe;
    end
    req_i_s = bus.i_req;
    req_d_s = bus.d_req;
  end

  // ---------------- drivers ----------------
  // Reference: ready k cycles after the strobe succeeds if k <= TMO, else times out.
  task automatic push_exp(input bit port_d, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [31:0] data, input int k);
    exp_t e;
    lat_tab[addr] = k;
    dat_tab[addr] = data;
    e.addr  = addr;
    e.wstrb = port_d ? wstrb : 4'b0000;
    e.wdata = wdata;
    e.err   = (k > TMO);
    e.rdata = (e.err || e.wstrb != 4'b0000) ? 32'h0 : data;
    e.lat   = e.err ? 8'(TMO + 1) : 8'(k + 1);
    if (port_d) exp_d_q.push_back(e);
    else exp_i_q.push_back(e);
  endtask

  task automatic do_req(input bit port_d, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic [31:0] data, input int k);
    int  n;
    bit  done;
    push_exp(port_d, addr, wstrb, wdata, data, k);
    if (port_d) begin
      bus.d_addr = addr; bus.d_wstrb = wstrb; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      done = port_d ? bus.d_done : bus.i_done;
    end while (!done && n < 200);
    if (!done) chk(port_d ? "d_done_timeout" : "i_done_timeout", 0, 1);
    if (port_d) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus.m_rstrb || bus.m_wstrb != 4'b0000) && n < 50);
    if (n >= 50) chk("wait_strobe_timeout", 0, 1);
  endtask

  task automatic rand_req(input bit port_d);
    logic [31:0] a;
    logic [3:0]  s;
    a = $urandom;
    a[0] = port_d;
    s = 4'b0000;
    if (port_d && $urandom_range(0, 1) == 1) s = 4'($urandom_range(1, 15));
    do_req(port_d, a, s, $urandom, $urandom, $urandom_range(0, TMO + 2));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit exp_seq[4];
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_wstrb = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single fetch, ready in ISSUE
    do_req(0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 0);
    repeat (2) @(posedge clk); #1;

    // byte store with three wait states
    do_req(1, 32'h203, 4'b1000, 32'h55555555, 32'h12345678, 3);
    repeat (2) @(posedge clk); #1;

    // round robin: two simultaneous pairs
    grant_log.delete();
    for (int p = 0; p < 2; p++) begin
      fork
        do_req(0, 32'h400 + 32'(p * 16), 4'b0000, 32'h0, $urandom, 1);
        do_req(1, 32'h501 + 32'(p * 16), 4'b0000, 32'h0, $urandom, 1);
      join
      @(posedge clk); #1;
    end
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk("rr_grant_count", grant_log.size(), 4);
    for (int g = 0; g < 4 && g < grant_log.size(); g++) chk("rr_grant_order", grant_log[g], exp_seq[g]);

    // timeout with stray ready in RESP, then in the following IDLE cycle
    do_req(1, 32'h601, 4'b0000, 32'h0, 32'hCAFEF00D, TMO + 1);
    repeat (3) @(posedge clk); #1;
    do_req(1, 32'h611, 4'b0000, 32'h0, 32'hCAFEF00D, TMO + 2);
    repeat (3) @(posedge clk); #1;
    do_req(0, 32'h620, 4'b0000, 32'h0, 32'h0BADCAFE, 2);
    repeat (2) @(posedge clk); #1;

    // reset during WAIT of a fetch
    push_exp(0, 32'h700, 4'b0000, 32'h0, 32'h77777777, 3);
    bus.i_addr = 32'h700; bus.i_req = 1'b1;
    wait_strobe();
    @(posedge clk); #1;
    chk("mid_reset_in_wait", dbg_state, 2);
    resetn = 1'b0;
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("mid_reset");
    exp_i_q.delete();
    model_last_d = 1'b1;
    resetn = 1'b1;
    repeat (8) @(posedge clk); #1;
    grant_log.delete();
    fork
      do_req(0, 32'h800, 4'b0000, 32'h0, $urandom, 0);
      do_req(1, 32'h801, 4'b0000, 32'h0, $urandom, 0);
    join
    chk("post_reset_tie_first_is_i", (grant_log.size() > 0) ? grant_log[0] : 1'b1, 0);
    repeat (2) @(posedge clk); #1;

    // request arriving while busy: ready in ISSUE, then ready after 2 waits
    for (int k = 0; k <= 2; k += 2) begin
      fork
        do_req(0, 32'h900 + 32'(k * 16), 4'b0000, 32'h0, $urandom, k);
        begin
          wait_strobe();
          if (k > 0) begin @(posedge clk); #1; end
          do_req(1, 32'h901 + 32'(k * 16), 4'b0010, $urandom, $urandom, 0);
        end
      join
      chk("busy_issue_spacing", strobe_cyc[1] - strobe_cyc[0], k + 3);
      repeat (2) @(posedge clk); #1;
    end

    // randomized concurrent traffic
    fork
      for (int n = 0; n < 30; n++) begin
        rand_req(0);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      for (int n = 0; n < 30; n++) begin
        rand_req(1);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    join

    repeat (10) @(posedge clk); #1;
    chk("exp_i_q_drained", exp_i_q.size(), 0);
    chk("exp_d_q_drained", exp_d_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (I) and the load/store unit requester (D).
- Per transaction: arbitrates between I and D, latches the request, issues one read or write strobe, waits for memory ready (bounded by a watchdog), and routes read data, done and error back to the winner.
- Sits between the control FSM / load-store unit and the memory.

Parameters:
- ADDR_W, 32, address width of all address ports.
- TIMEOUT, 255, max cycles in WAIT before the transaction is aborted with error; legal range 1..65535.
- CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- resetn  input  1  synchronous, active-low reset.
- i_req  input  1  fetch request; held high until i_done.
- i_addr  input  ADDR_W  fetch address.
- i_rdata  output  32  fetch read data; valid while i_done=1.
- i_done  output  1  one-cycle completion pulse to I.
- i_err  output  1  timeout flag; qualified by i_done.
- d_req  input  1  data request; held high until d_done.
- d_addr  input  ADDR_W  data address, already aligned by the LSU.
- d_wdata  input  32  store data, already lane-replicated.
- d_wstrb  input  4  byte-enable write mask; 4'b0000 means read.
- d_rdata  output  32  raw memory word to the LSU; valid while d_done=1.
- d_done  output  1  one-cycle completion pulse to D.
- d_err  output  1  timeout flag; qualified by d_done.
- m_addr  output  ADDR_W  memory address.
- m_wdata  output  32  memory write data.
- m_wstrb  output  4  memory byte write strobes.
- m_rstrb  output  1  memory read strobe.
- m_rdata  input  32  memory read data; valid with m_ready.
- m_ready  input  1  memory completion for the issued access.

Behaviour:
- Reset (resetn=0 at an edge):
  - State goes to IDLE; last_grant=D; watchdog=0.
  - All outputs go to 0, including m_addr, m_wdata, i_rdata and d_rdata.
  - A transaction in flight is dropped: no done, no error.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not last_grant (round robin); after reset, I wins the first tie.
  - On grant: latch addr to m_addr; latch wdata/wstrb (D only; I always reads, wstrb=0); update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Read: m_rstrb=1. Write: m_wstrb=latched mask and m_rstrb=0.
  - m_ready=1 in this cycle: capture m_rdata and go to RESP.
  - Otherwise clear the watchdog and go to WAIT.
- WAIT:
  - Strobes are 0; m_addr and m_wdata are held.
  - m_ready=1: capture m_rdata and go to RESP with err=0.
  - Otherwise increment the watchdog.
  - Watchdog == TIMEOUT-1 with no m_ready: go to RESP with err=1 and rdata=0.
- RESP (1 cycle):
  - Winner's done=1, rdata=captured word, err as set.
  - Non-winner outputs stay 0.
  - Next state is IDLE.
  - Requests are not sampled in RESP; the requester drops req on the cycle after done.
- rdata/err outputs return to 0 when done drops.
- m_ready is ignored in IDLE and RESP. A late ready after a timeout is discarded.
- For writes, m_rdata is not captured; the requester's rdata is 0 in RESP.
- Latency:
  - Req sampled in IDLE at edge N: strobe visible in cycle N+1.
  - Best case: done in cycle N+2 (ready in ISSUE).
  - Ready k cycles after ISSUE: done at N+2+k.
  - Timeout: done at N+2+TIMEOUT.
- Back-to-back: after RESP there is one IDLE cycle, so the minimum issue-to-issue spacing is 3 cycles.
- A req that rises during ISSUE/WAIT/RESP waits and is arbitrated at the next IDLE.
- A req dropped before grant is simply not served.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ready in ISSUE with m_rdata=0xDEADBEEF -> m_rstrb high exactly 1 cycle with m_addr=0x100; i_done pulse 2 cycles after sampling; i_rdata=0xDEADBEEF; i_err=0; d_done stays 0.
- Byte store with wait states: d_req=1, d_addr=0x203, d_wstrb=4'b1000, d_wdata=0x55555555, m_ready 3 cycles after ISSUE -> m_wstrb=4'b1000 for 1 cycle only; m_rstrb=0; d_done 5 cycles after sampling; d_rdata=0.
- Round robin: i_req and d_req both held high from reset, each dropped after its done -> grant order I, D; a second simultaneous pair gives I then D again (last_grant alternates); no overlapping strobes.
- Timeout with TIMEOUT=4: d read, m_ready never asserted -> d_done with d_err=1 and d_rdata=0 at ISSUE+5; a stray m_ready one cycle later is ignored, no extra done.
- Reset mid-operation: resetn=0 during WAIT of an I read -> next cycle all outputs are 0 and state is IDLE; after release, no i_done until a new request; a subsequent tie goes to I.
- Request during busy: d_req rises during WAIT of an I access -> D is granted in the IDLE cycle after I's RESP; D's strobe appears exactly 3 cycles after I's ISSUE when ready came in I's ISSUE.
